// File: rtl/comparator_sweep_driver_pkg.sv
// Shared definitions for the comparator sweep driver: FSM state encodings and
// the bit positions of the GT/EQ/LT flags inside a 3-bit flag vector.
package comparator_sweep_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;

endpackage

// File: rtl/comparator_sweep_driver_cmp_golden.sv
// Combinational golden magnitude comparator: the expected {GT, EQ, LT} flags
// for a pair of unsigned WIDTH-bit operands.
module cmp_golden
  import comparator_sweep_driver_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [2:0]       exp_flags
);

  always_comb begin
    exp_flags          = '0;
    exp_flags[FLAG_GT] = (a_in > b_in);
    exp_flags[FLAG_EQ] = (a_in == b_in);
    exp_flags[FLAG_LT] = (a_in < b_in);
  end

endmodule

// File: rtl/comparator_sweep_driver.sv
// Exhaustive sweep of every {A,B} operand pair onto an external comparator,
// checking its flags against cmp_golden. Build option: CMP_SWEEP_STOP_ON_FAIL_EN.
module comparator_sweep_driver
  import comparator_sweep_driver_pkg::*;
#(
  parameter  int WIDTH  = 1,
  parameter  int SETTLE = 1,
  localparam int ERR_W  = 2*WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  input  logic             GT_in,
  input  logic             EQ_in,
  input  logic             LT_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output state_e           dbg_state
);

  // Handshake: start is a single-cycle request; it is accepted only in IDLE or
  // DONE (busy=0) and is ignored while busy=1. There is no ready/ack back.

  localparam int IDX_W = 2*WIDTH;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [2:0]       exp_flags;
  logic [2:0]       obs_flags;
  logic             mismatch;

  cmp_golden #(.WIDTH(WIDTH)) u_golden (
    .a_in      (a_q),
    .b_in      (b_q),
    .exp_flags (exp_flags)
  );

  // Any flag pattern that is not exactly the golden one-hot vector is an error.
  always_comb begin
    obs_flags          = '0;
    obs_flags[FLAG_GT] = GT_in;
    obs_flags[FLAG_EQ] = EQ_in;
    obs_flags[FLAG_LT] = LT_in;
    mismatch           = (obs_flags != exp_flags);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          err_d   = '0;
        end
      end
      ST_DRIVE: begin
        a_d     = idx_q[IDX_W-1:WIDTH];
        b_d     = idx_q[WIDTH-1:0];
        cnt_d   = CNT_LOAD;
        state_d = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
`ifdef CMP_SWEEP_STOP_ON_FAIL_EN
        if (mismatch || (idx_q == '1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end
`else
        if (idx_q == '1) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign A_out     = a_q;
  assign B_out     = b_q;
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = (state_q == ST_DONE) && (err_q == '0);
  assign err_count = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_comparator_sweep_driver.sv
// Bench for comparator_sweep_driver: three instances (WIDTH/SETTLE = 1/1, 2/3,
// 3/0), each driven by a behavioural comparator with selectable faults.
module tb_comparator_sweep_driver;
  import comparator_sweep_driver_pkg::*;

  localparam int LIMIT = 2000;
  localparam int W_OF [3] = '{1, 2, 3};
  localparam int S_OF [3] = '{1, 3, 0};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] start = '0;
  logic [2:0] busy, done, pass;
  logic [0:0] a0, b0;
  logic [1:0] a1, b1;
  logic [2:0] a2, b2;
  logic [2:0] f0, f1, f2;
  logic [2:0] err0;
  logic [4:0] err1;
  logic [6:0] err2;
  state_e     st0, st1, st2;

  int         mode [3] = '{0, 0, 0};
  logic [2:0] mask [64];
  int         sel = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  // Comparator under test: 0 correct, 1 EQ stuck 0, 2 GT stuck 0,
  // 3 GT stuck 1, 4 correct flags XOR a per-vector random mask.
  function automatic logic [2:0] bench_cmp(input int a, input int b, input int m, input logic [2:0] x);
    logic [2:0] t;
    t = {a > b, a == b, a < b};
    case (m)
      1:       return t & 3'b101;
      2:       return t & 3'b011;
      3:       return t | 3'b100;
      4:       return t ^ x;
      default: return t;
    endcase
  endfunction

  function automatic void model_errors(input int w, input int m, output int n, output int first);
    int a, b;
    logic [2:0] truth;
    n = 0;
    first = -1;
    for (int k = 0; k < (1 << (2*w)); k++) begin
      a = k >> w;
      b = k & ((1 << w) - 1);
      truth = {a > b, a == b, a < b};
      if (bench_cmp(a, b, m, mask[k]) !== truth) begin
        if (first < 0) first = k;
        n++;
      end
    end
  endfunction

  always_comb f0 = bench_cmp(int'(a0), int'(b0), mode[0], mask[int'({a0, b0})]);
  always_comb f1 = bench_cmp(int'(a1), int'(b1), mode[1], mask[int'({a1, b1})]);
  always_comb f2 = bench_cmp(int'(a2), int'(b2), mode[2], mask[int'({a2, b2})]);

  comparator_sweep_driver #(.WIDTH(1), .SETTLE(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .A_out(a0), .B_out(b0),
    .GT_in(f0[2]), .EQ_in(f0[1]), .LT_in(f0[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err0), .dbg_state(st0)
  );
  comparator_sweep_driver #(.WIDTH(2), .SETTLE(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .A_out(a1), .B_out(b1),
    .GT_in(f1[2]), .EQ_in(f1[1]), .LT_in(f1[0]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err1), .dbg_state(st1)
  );
  comparator_sweep_driver #(.WIDTH(3), .SETTLE(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .A_out(a2), .B_out(b2),
    .GT_in(f2[2]), .EQ_in(f2[1]), .LT_in(f2[0]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(err2), .dbg_state(st2)
  );

  // Observation mux over the selected instance.
  logic   obs_busy, obs_done, obs_pass;
  int     obs_err, obs_ab;
  state_e obs_st;
  always_comb begin
    obs_busy = busy[sel];
    obs_done = done[sel];
    obs_pass = pass[sel];
    case (sel)
      1:       begin obs_err = int'(err1); obs_ab = int'({a1, b1}); obs_st = st1; end
      2:       begin obs_err = int'(err2); obs_ab = int'({a2, b2}); obs_st = st2; end
      default: begin obs_err = int'(err0); obs_ab = int'({a0, b0}); obs_st = st0; end
    endcase
  end

  // driver: pulse start, follow the sweep, check the driven vector each cycle
  task automatic run_sweep(input int d, input int extra_at, input int rst_at, output int cycles);
    int c, s, k, ph;
    sel = d;
    s = S_OF[d];
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
    c = 0;
    while (obs_busy && c < LIMIT) begin
      c++;
      ph = (c - 1) % (s + 2);
      k  = (c - 1) / (s + 2);
      if (ph >= 1) begin
        n_checks++;
        if (obs_ab !== k) $display("FAIL vector_d%0d_c%0d got %0d want %0d", d, c, obs_ab, k);
        else n_pass++;
      end
      if (c == extra_at) start[d] = 1'b1;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        cycles = c;
        return;
      end
      @(negedge clk);
      start[d] = 1'b0;
    end
    n_checks++;
    if (c >= LIMIT) $display("FAIL timeout_d%0d got %0d cycles want < %0d", d, c, LIMIT);
    else n_pass++;
    cycles = c;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      n_checks++;
      if ({obs_busy, obs_done, obs_pass} !== 3'b000 || obs_err !== 0 || obs_ab !== 0 || obs_st !== ST_IDLE)
        $display("FAIL reset_d%0d got b%0b d%0b p%0b err%0d ab%0d st%0d want all 0 IDLE",
                 d, obs_busy, obs_done, obs_pass, obs_err, obs_ab, obs_st);
      else n_pass++;
    end
  endtask

  task automatic test_sweep(input int d, input int m, input int extra_at, input string name);
    int cyc, n, first, w, s, nvec, exp_cyc, exp_err, exp_ab;
    mode[d] = m;
    w = W_OF[d];
    s = S_OF[d];
    nvec = 1 << (2*w);
    model_errors(w, m, n, first);
`ifdef CMP_SWEEP_STOP_ON_FAIL_EN
    if (n > 0) begin
      exp_err = 1; exp_cyc = (first + 1) * (s + 2); exp_ab = first;
    end else begin
      exp_err = 0; exp_cyc = nvec * (s + 2); exp_ab = nvec - 1;
    end
`else
    exp_err = n; exp_cyc = nvec * (s + 2); exp_ab = nvec - 1;
`endif
    run_sweep(d, extra_at, 0, cyc);
    n_checks++;
    if (cyc !== exp_cyc) $display("FAIL %s_cycles got %0d want %0d", name, cyc, exp_cyc);
    else n_pass++;
    n_checks++;
    if (obs_err !== exp_err) $display("FAIL %s_err got %0d want %0d", name, obs_err, exp_err);
    else n_pass++;
    n_checks++;
    if (obs_done !== 1'b1 || obs_busy !== 1'b0) $display("FAIL %s_done got d%0b b%0b want d1 b0", name, obs_done, obs_busy);
    else n_pass++;
    n_checks++;
    if (obs_pass !== (exp_err == 0)) $display("FAIL %s_pass got %0b want %0b", name, obs_pass, exp_err == 0);
    else n_pass++;
    n_checks++;
    if (obs_ab !== exp_ab) $display("FAIL %s_hold_ab got %0d want %0d", name, obs_ab, exp_ab);
    else n_pass++;
  endtask

  task automatic test_index11();
    int c;
    mode[1] = 0;
    sel = 1;
    @(negedge clk); start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    c = 1;
    while (c < 11*5 + 3) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (a1 !== 2'd2 || b1 !== 2'd3 || f1 !== 3'b001)
      $display("FAIL index11 got a%0d b%0d flags%0b want a2 b3 flags001", a1, b1, f1);
    else n_pass++;
    c = 0;
    while (busy[1] && c < LIMIT) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    mode[1] = 0;
    run_sweep(1, 0, 7, cyc);
    n_checks++;
    if ({obs_busy, obs_done, obs_pass} !== 3'b000 || obs_err !== 0 || obs_ab !== 0 || obs_st !== ST_IDLE)
      $display("FAIL reset_mid got b%0b d%0b p%0b err%0d ab%0d st%0d want all 0 IDLE",
               obs_busy, obs_done, obs_pass, obs_err, obs_ab, obs_st);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    test_sweep(1, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 64; k++)
        mask[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      test_sweep(it % 3, 4, 0, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mask[k] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_sweep(0, 0, 0, "w1_correct");
    test_sweep(0, 1, 0, "w1_eq_stuck0");
    test_sweep(0, 2, 0, "w1_gt_stuck0");
    test_sweep(0, 3, 0, "w1_gt_stuck1");
    test_sweep(1, 0, 0, "w2_correct");
    test_sweep(1, 0, 5, "w2_start_ignored");
    test_sweep(2, 0, 0, "w3_settle0");
    test_sweep(2, 1, 0, "w3_eq_stuck0");
    test_index11();
    test_reset_mid();
    test_random();
    test_sweep(0, 0, 0, "back_to_back");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
